bundler_hf: RTL

Majority-vote bundler for the hardware-friendly HDC seizure-detection datapath. It sits directly downstream of `binder_hf` and consumes each bound hypervector when the binder's `out` strobe marks it valid. It accumulates per-dimension bit counts over a window of `NUM_INPUTS` hypervectors, then emits one bundled hypervector with a one-cycle completion strobe to the next stage.

---
 rtl/bundler_hf.sv | 65 ++++++
 1 files changed

// File: rtl/bundler_hf.sv
// bundler_hf: majority-vote bundler, bundles NUM_INPUTS hypervectors per window
// Ports: clk, nrst (sync active-low reset), en (input valid), clr (abort window),
//        hv_in (bound hypervector), out (one-cycle bundle-ready pulse),
//        hv_out (registered bundle), busy (window partially filled)
module bundler_hf #(
   parameter int DIMENSIONS = 5,
   parameter int NUM_INPUTS = 3
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [DIMENSIONS-1:0] hv_in,
   output logic                  out,
   output logic [DIMENSIONS-1:0] hv_out,
   output logic                  busy
);
   localparam int CNT_W = $clog2(NUM_INPUTS + 1);
   typedef enum logic {IDLE, ACCUM} state_t;
   state_t state;
   logic [DIMENSIONS-1:0][CNT_W-1:0] cnt;
   logic [CNT_W-1:0] n_cnt;
   logic [DIMENSIONS-1:0] first_hv, maj;
   logic last;
   assign last = n_cnt == CNT_W'(NUM_INPUTS - 1);
   assign busy = state == ACCUM;
   // sum includes the current input; ties fall back to the window's first vector
   for (genvar d = 0; d < DIMENSIONS; d++) begin : g_maj
      logic [CNT_W:0] s;
      logic [CNT_W+1:0] s2;
      assign s = {1'b0, cnt[d]} + {{CNT_W{1'b0}}, hv_in[d]};
      assign s2 = {s, 1'b0};
      assign maj[d] = s2 > (CNT_W+2)'(NUM_INPUTS) ? 1'b1 :
                      s2 < (CNT_W+2)'(NUM_INPUTS) ? 1'b0 : first_hv[d];
   end
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state <= IDLE;
         cnt <= '0;
         n_cnt <= '0;
         first_hv <= '0;
         hv_out <= '0;
         out <= 1'b0;
      end else if (clr) begin
         state <= IDLE;
         cnt <= '0;
         n_cnt <= '0;
         out <= 1'b0;
      end else if (en && last) begin
         state <= IDLE;
         cnt <= '0;
         n_cnt <= '0;
         hv_out <= maj;
         out <= 1'b1;
      end else begin
         out <= 1'b0;
         if (en) begin
            for (int i = 0; i < DIMENSIONS; i++) cnt[i] <= cnt[i] + CNT_W'(hv_in[i]);
            n_cnt <= n_cnt + 1'b1;
            state <= ACCUM;
            if (n_cnt == '0) first_hv <= hv_in;
         end
      end
   end
endmodule
